f1_reaction_timer: RTL and testbench
====================================

# f1_reaction_timer

Random-hold and reaction-measurement stage for the Formula One lights game. It sits directly downstream of the light sequencer and consumes its `start_delay` level. When the sequencer reaches all-lights-on, the block holds for a pseudo-random time built from the LFSR value, then raises `time_out` so the lights go out. It then counts elapsed milliseconds in BCD until the player presses the reaction key, and flags any press before lights-out as a false start.

## Interface

**Parameters**
- `LFSR_W`, default 7: width of the random seed input.
- `DELAY_SHIFT`, default 4: left shift applied to `lfsr_q` to form the random part of the hold.
- `MIN_DELAY_MS`, default 500: fixed minimum hold, in ms.
- `DLY_W`, default 12: hold down-counter width. Must hold `MIN_DELAY_MS + ((2^LFSR_W - 1) << DELAY_SHIFT)`.

**Ports** (clock and reset first)
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `tick_ms`, in, 1: one-`clk`-cycle enable, once per millisecond.
- `start_delay`, in, 1: level from the sequencer, high while all lights are on.
- `lfsr_q`, in, `LFSR_W`: random value, sampled on the `start_delay` rising edge.
- `react`, in, 1: reaction key, active-high, already synchronised to `clk`.
- `time_out`, out, 1: lights-out request to the sequencer.
- `bcd`, out, 16: four BCD digits, `[15:12]` thousands … `[3:0]` units, in ms.
- `result_valid`, out, 1: a valid reaction time is on `bcd`.
- `too_early`, out, 1: false start detected.

## Operation

**Edge detection**
- `start_delay` and `react` are each registered once.
- `start_rise = start_delay & ~start_q`.
- `react_rise = react & ~react_q`.

**States:** IDLE, HOLD, TIMING, DONE, FALSE_START.

- **IDLE**
  - On `start_rise`: load `dly_cnt = MIN_DELAY_MS + (lfsr_q << DELAY_SHIFT)`, clear `bcd`, `result_valid` and `too_early`, go to HOLD.
- **HOLD**
  - On `tick_ms`: `dly_cnt` decrements.
  - On a `tick_ms` with `dly_cnt == 1`: go to TIMING, set `time_out`.
  - On `react_rise`: go to FALSE_START, set `too_early` and `time_out`. This takes priority over expiry in the same cycle.
- **TIMING**
  - On `tick_ms`: `bcd` increments in decimal. It saturates at 16'h9999 and never wraps.
  - On `react_rise`: freeze `bcd`, set `result_valid`, go to DONE. If `react_rise` and `tick_ms` arrive in the same cycle, `react_rise` wins and `bcd` keeps its pre-tick value.
- **DONE / FALSE_START**
  - Outputs hold.
  - On `start_rise`: reload as in IDLE and go to HOLD.

**Handshake**
- `time_out` is a level, not a pulse, because the sequencer may run on a slower clock.
- It is set as described above and cleared in the first cycle `start_delay` is low.
- `start_rise` while in HOLD or TIMING is ignored; `start_delay` is already high there.

**Reset**
- `rst_n` low at any time forces, asynchronously:
  - state = IDLE;
  - `time_out` = 0, `bcd` = 0, `result_valid` = 0, `too_early` = 0;
  - `dly_cnt` = 0, `start_q` = 0, `react_q` = 0.

## Timing

- All outputs are registered and change one `clk` after the causing edge or tick.
- Hold length is exactly `MIN_DELAY_MS + (lfsr_q << DELAY_SHIFT)` ticks after `start_rise`. `time_out` rises in the `clk` cycle after the final tick.
- Reaction resolution is 1 ms. `bcd` equals the number of `tick_ms` strictly between `time_out` rising and `react_rise`, capped at 9999.
- A `react` held high across lights-out produces no `react_rise`. That case counts as a false start only if the press began in HOLD.

## Structure

- Package `f1_pkg` holds:
  - state enum `react_state_t`;
  - type `bcd_digit_t` (logic [3:0]);
  - constant `BCD_MAX` = 16'h9999.
- Sub-module `bcd_counter4`:
  - ports: clear, enable, freeze;
  - four cascaded mod-10 digits with carry chain and saturate at 9999.
- The top holds the FSM, edge detectors and hold down-counter.

## Test plan

1. `lfsr_q`=7'd3, `start_delay` rises → `time_out` rises exactly 548 ticks later (500 + 48); `bcd`=0.
2. After `time_out`, apply 237 ticks then a `react` rise → `bcd`=16'h0237, `result_valid`=1, state DONE.
3. `react` rises at tick 100 of HOLD → `too_early`=1 and `time_out`=1 the next `clk`; `bcd`=0; `result_valid`=0; `time_out` clears when `start_delay` falls.
4. No `react` for 10005 ticks in TIMING → `bcd` holds 16'h9999, no wrap; 16'h0009 → 16'h0010 and 16'h0999 → 16'h1000 carries checked on the way.
5. `tick_ms` and `react_rise` in the same cycle with `bcd`=16'h0041 → final `bcd`=16'h0041.
6. `rst_n` low mid-TIMING → all outputs 0 immediately (asynchronous); after release, a new `start_rise` runs a full HOLD and TIMING correctly.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 lights reaction timer.
//   react_state_t : reaction-timer FSM states
//   bcd_digit_t   : one packed BCD digit
//   BCD_MAX       : saturation value of the 4-digit ms counter
//   bcd_inc       : mod-10 increment of a single digit
package f1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HOLD        = 3'd1,
        ST_TIMING      = 3'd2,
        ST_DONE        = 3'd3,
        ST_FALSE_START = 3'd4
    } react_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit cascaded BCD up-counter that saturates at 9999.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0000 (wins over everything else)
//   enable     : count one step this cycle
//   freeze     : suppress a count that would otherwise happen this cycle
//   bcd        : [15:12] thousands ... [3:0] units
module bcd_counter4
    import f1_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        freeze,
    output logic [15:0] bcd
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        carry;
    bcd_digit_t  digit;

    always_comb begin
        cnt_d = cnt_q;
        digit = 4'd0;
        // Counting stops at 9999 instead of rolling over to 0000.
        carry = enable & ~freeze & (cnt_q != BCD_MAX);
        for (int i = 0; i < 4; i++) begin
            digit = cnt_q[i*4 +: 4];
            if (carry) begin
                cnt_d[i*4 +: 4] = bcd_inc(digit);
            end
            // A digit passes the carry on only when it wraps 9 -> 0.
            carry = carry & (digit == 4'd9);
        end
        if (clear) begin
            cnt_d = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bcd = cnt_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// Random hold and reaction measurement for the F1 lights game.
// When start_delay rises the block holds for MIN_DELAY_MS + (lfsr_q << DELAY_SHIFT)
// ms, raises time_out (lights out), then counts ms in BCD until the reaction key
// is pressed. A press during the hold is a false start.
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick_ms      : one-cycle enable per millisecond
//   start_delay  : level from the sequencer, high while all lights are on
//   lfsr_q       : random seed, sampled on the start_delay rising edge
//   react        : synchronised reaction key, active-high
//   time_out     : lights-out request (level, cleared once start_delay is low)
//   bcd          : reaction time in ms, four BCD digits
//   result_valid : bcd holds a valid reaction time
//   too_early    : false start detected
// Handshake: time_out is a level so a slower-clocked sequencer cannot miss it; it
// stays high until the sequencer drops start_delay.
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int LFSR_W       = 7,
    parameter int DELAY_SHIFT  = 4,
    parameter int MIN_DELAY_MS = 500,
    parameter int DLY_W        = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_ms,
    input  logic              start_delay,
    input  logic [LFSR_W-1:0] lfsr_q,
    input  logic              react,
    output logic              time_out,
    output logic [15:0]       bcd,
    output logic              result_valid,
    output logic              too_early
);

    react_state_t     state_q, state_d;
    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic             time_out_q, time_out_d;
    logic             result_valid_q, result_valid_d;
    logic             too_early_q, too_early_d;
    logic             start_q, react_q;

    logic             start_rise;
    logic             react_rise;
    logic [DLY_W-1:0] dly_load;
    logic             bcd_clear;
    logic             bcd_en;
    logic             bcd_freeze;

    assign start_rise = start_delay & ~start_q;
    assign react_rise = react & ~react_q;
    assign dly_load   = DLY_W'(MIN_DELAY_MS) + (DLY_W'(lfsr_q) << DELAY_SHIFT);

    always_comb begin
        state_d        = state_q;
        dly_cnt_d      = dly_cnt_q;
        time_out_d     = time_out_q;
        result_valid_d = result_valid_q;
        too_early_d    = too_early_q;
        bcd_clear      = 1'b0;
        bcd_en         = 1'b0;
        bcd_freeze     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FALSE_START: begin
                if (start_rise) begin
                    dly_cnt_d      = dly_load;
                    result_valid_d = 1'b0;
                    too_early_d    = 1'b0;
                    bcd_clear      = 1'b1;
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A press beats expiry landing in the same cycle.
                if (react_rise) begin
                    too_early_d = 1'b1;
                    time_out_d  = 1'b1;
                    state_d     = ST_FALSE_START;
                end else if (tick_ms) begin
                    if (dly_cnt_q <= DLY_W'(1)) begin
                        dly_cnt_d  = '0;
                        time_out_d = 1'b1;
                        state_d    = ST_TIMING;
                    end else begin
                        dly_cnt_d = dly_cnt_q - DLY_W'(1);
                    end
                end
            end
            ST_TIMING: begin
                // freeze drops a tick that coincides with the press, so bcd
                // keeps its pre-tick value.
                bcd_en     = tick_ms;
                bcd_freeze = react_rise;
                if (react_rise) begin
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!start_delay) begin
            time_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            dly_cnt_q      <= '0;
            time_out_q     <= 1'b0;
            result_valid_q <= 1'b0;
            too_early_q    <= 1'b0;
            start_q        <= 1'b0;
            react_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            dly_cnt_q      <= dly_cnt_d;
            time_out_q     <= time_out_d;
            result_valid_q <= result_valid_d;
            too_early_q    <= too_early_d;
            start_q        <= start_delay;
            react_q        <= react;
        end
    end

    bcd_counter4 u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bcd_clear),
        .enable (bcd_en),
        .freeze (bcd_freeze),
        .bcd    (bcd)
    );

    assign time_out     = time_out_q;
    assign result_valid = result_valid_q;
    assign too_early    = too_early_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer with hand-computed expected values.
module tb_f1_reaction_timer;
    import f1_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        tick_ms;
    logic        start_delay;
    logic [6:0]  lfsr_q;
    logic        react;
    logic        time_out;
    logic [15:0] bcd;
    logic        result_valid;
    logic        too_early;

    int total;
    int bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    f1_reaction_timer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_ms      (tick_ms),
        .start_delay  (start_delay),
        .lfsr_q       (lfsr_q),
        .react        (react),
        .time_out     (time_out),
        .bcd          (bcd),
        .result_valid (result_valid),
        .too_early    (too_early)
    );

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Every driver returns 1 time unit after a rising edge, so inputs change
    // away from the edge and outputs sampled there are already settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
            step();
        end
    endtask

    task automatic start_round(input logic [6:0] seed);
        lfsr_q      = seed;
        start_delay = 1'b1;
        step();
    endtask

    task automatic end_round();
        start_delay = 1'b0;
        step();
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        tick_ms     = 1'b0;
        start_delay = 1'b0;
        lfsr_q      = 7'd0;
        react       = 1'b0;
        repeat (3) step();

        check_eq("rst_time_out", 32'(time_out), 32'd0);
        check_eq("rst_bcd", 32'(bcd), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_early", 32'(too_early), 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        // 1) seed 3 -> hold of 500 + 48 = 548 ticks
        start_round(7'd3);
        check_eq("t1_state_hold", 32'(dut.state_q), 32'(ST_HOLD));
        check_eq("t1_dly_load", 32'(dut.dly_cnt_q), 32'd548);
        do_ticks(547);
        check_eq("t1_to_before", 32'(time_out), 32'd0);
        do_ticks(1);
        check_eq("t1_to_after", 32'(time_out), 32'd1);
        check_eq("t1_state_timing", 32'(dut.state_q), 32'(ST_TIMING));
        check_eq("t1_bcd0", 32'(bcd), 32'h0);

        // 2) 237 ticks then a press
        do_ticks(237);
        check_eq("t2_valid_pre", 32'(result_valid), 32'd0);
        react = 1'b1;
        step();
        check_eq("t2_bcd", 32'(bcd), 32'h0237);
        check_eq("t2_valid", 32'(result_valid), 32'd1);
        check_eq("t2_state_done", 32'(dut.state_q), 32'(ST_DONE));
        do_ticks(5);
        check_eq("t2_bcd_hold", 32'(bcd), 32'h0237);
        react = 1'b0;
        step();
        end_round();
        check_eq("t2_to_clear", 32'(time_out), 32'd0);

        // 3) false start at tick 100 of a 500-tick hold
        start_round(7'd0);
        check_eq("t3_bcd_clr", 32'(bcd), 32'h0);
        check_eq("t3_valid_clr", 32'(result_valid), 32'd0);
        do_ticks(100);
        react = 1'b1;
        step();
        check_eq("t3_early", 32'(too_early), 32'd1);
        check_eq("t3_time_out", 32'(time_out), 32'd1);
        check_eq("t3_bcd", 32'(bcd), 32'h0);
        check_eq("t3_valid", 32'(result_valid), 32'd0);
        check_eq("t3_state", 32'(dut.state_q), 32'(ST_FALSE_START));
        do_ticks(450);
        check_eq("t3_to_held", 32'(time_out), 32'd1);
        check_eq("t3_state_held", 32'(dut.state_q), 32'(ST_FALSE_START));
        react = 1'b0;
        end_round();
        check_eq("t3_to_clear", 32'(time_out), 32'd0);
        check_eq("t3_early_held", 32'(too_early), 32'd1);

        // 5) tick and press in the same cycle at 41 ms: tick is dropped
        start_round(7'd1);
        check_eq("t5_early_clr", 32'(too_early), 32'd0);
        do_ticks(516);
        check_eq("t5_to", 32'(time_out), 32'd1);
        do_ticks(41);
        check_eq("t5_bcd_pre", 32'(bcd), 32'h0041);
        tick_ms = 1'b1;
        react   = 1'b1;
        step();
        tick_ms = 1'b0;
        check_eq("t5_bcd_same", 32'(bcd), 32'h0041);
        check_eq("t5_valid", 32'(result_valid), 32'd1);
        step();
        check_eq("t5_bcd_final", 32'(bcd), 32'h0041);
        end_round();

        // 4) key held since before the hold: no false start, then saturation
        start_round(7'd2);
        do_ticks(532);
        check_eq("t4_early", 32'(too_early), 32'd0);
        check_eq("t4_to", 32'(time_out), 32'd1);
        do_ticks(9);
        check_eq("t4_bcd_9", 32'(bcd), 32'h0009);
        do_ticks(1);
        check_eq("t4_bcd_10", 32'(bcd), 32'h0010);
        do_ticks(989);
        check_eq("t4_bcd_999", 32'(bcd), 32'h0999);
        do_ticks(1);
        check_eq("t4_bcd_1000", 32'(bcd), 32'h1000);
        do_ticks(8999);
        check_eq("t4_bcd_9999", 32'(bcd), 32'h9999);
        do_ticks(6);
        check_eq("t4_bcd_sat", 32'(bcd), 32'h9999);
        check_eq("t4_valid_pre", 32'(result_valid), 32'd0);
        react = 1'b0;
        step();
        react = 1'b1;
        step();
        check_eq("t4_valid", 32'(result_valid), 32'd1);
        check_eq("t4_bcd_done", 32'(bcd), 32'h9999);
        react = 1'b0;
        end_round();

        // 6) asynchronous reset mid-TIMING, then a full clean round
        start_round(7'd3);
        do_ticks(548);
        do_ticks(20);
        check_eq("t6_bcd_pre", 32'(bcd), 32'h0020);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_to", 32'(time_out), 32'd0);
        check_eq("t6_rst_bcd", 32'(bcd), 32'h0);
        check_eq("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        start_delay = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        start_round(7'd5);
        do_ticks(579);
        check_eq("t6_to_before", 32'(time_out), 32'd0);
        do_ticks(1);
        check_eq("t6_to_after", 32'(time_out), 32'd1);
        do_ticks(77);
        react = 1'b1;
        step();
        check_eq("t6_bcd", 32'(bcd), 32'h0077);
        check_eq("t6_valid", 32'(result_valid), 32'd1);
        react = 1'b0;
        end_round();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
